// File: rtl/alu_responder.sv
// alu_responder: handshaked sequential ALU with registered Result/Zero and a valid/ready response.
// Define ALU_MULT_EN to build the iterative shift-add multiply for ALUctr 011.
module alu_responder #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUctr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // CALC is the cycle after acceptance where the latched operands are evaluated.
`ifdef ALU_MULT_EN
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, MUL, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] alu_res;

`ifdef ALU_MULT_EN
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mul_sum;

  assign mul_sum = acc_q + (b_q[0] ? a_q : '0);
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: begin
`ifdef ALU_MULT_EN
        state_d = (op_q == OP_MUL) ? MUL : DONE;
`else
        state_d = DONE;
`endif
      end
`ifdef ALU_MULT_EN
      MUL:  if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Multiply walks B LSB first; a_q/b_q are consumed as shift registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      Result <= '0;
      Zero   <= 1'b1;
`ifdef ALU_MULT_EN
      acc_q  <= '0;
      cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= ALUctr;
`ifdef ALU_MULT_EN
            acc_q <= '0;
            cnt_q <= '0;
`endif
          end
        end
        CALC: begin
`ifdef ALU_MULT_EN
          if (op_q != OP_MUL) begin
            Result <= alu_res;
            Zero   <= (alu_res == '0);
          end
`else
          Result <= alu_res;
          Zero   <= (alu_res == '0);
`endif
        end
`ifdef ALU_MULT_EN
        MUL: begin
          acc_q <= mul_sum;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          if (cnt_q == CW'(WIDTH-1)) begin
            Result <= mul_sum;
            Zero   <= (mul_sum == '0);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
